// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: store funct3 encodings, store-unit error codes and
// the write-register state encoding.
package rv32i_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic {
        MWR_IDLE = 1'b0,
        MWR_BUSY = 1'b1
    } mwr_state_e;

endpackage

// File: rtl/store_lane_align.sv
// Combinational store aligner: replicates rs2 data across byte lanes, builds
// byte enables and classifies the store as misaligned or illegal.
module store_lane_align
    import rv32i_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [31:0] data,
    input  logic [2:0]  funct3,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        misaligned,
    output logic        illegal
);

    // NOTE: every output gets a default before the case so no path can leave
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        wdata      = '0;
        be         = '0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (funct3)
            F3_SB: begin
                wdata = {4{data[7:0]}};
                be    = 4'b0001 << addr;
            end
            F3_SH: begin
                wdata      = {2{data[15:0]}};
                be         = 4'b0011 << addr;
                misaligned = addr[0];
            end
            F3_SW: begin
                wdata      = data;
                be         = 4'b1111;
                misaligned = |addr;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/memory_write_register.sv
// Single-entry store register: accepts one store from the core, drives a
// req/ack write to data memory and reports completion, errors or timeout.
module memory_write_register
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int TIMEOUT_W = 5
) (
    input  logic        mwr_clk,
    input  logic        mwr_rst_n,
    input  logic        mwr_st_valid,
    output logic        mwr_st_ready,
    input  logic [31:0] mwr_st_addr,
    input  logic [31:0] mwr_st_data,
    input  logic [2:0]  mwr_st_funct3,
    output logic        mwr_mem_req,
    output logic [31:0] mwr_mem_addr,
    output logic [31:0] mwr_mem_wdata,
    output logic [3:0]  mwr_mem_be,
    input  logic        mwr_mem_ack,
    output logic        mwr_done,
    output logic        mwr_err,
    output logic [1:0]  mwr_err_code
);

    mwr_state_e           state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 mem_req_q, mem_req_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [31:0]          mem_wdata_q, mem_wdata_d;
    logic [3:0]           mem_be_q, mem_be_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [1:0]           err_code_q, err_code_d;

    logic [31:0] al_wdata;
    logic [3:0]  al_be;
    logic        al_misaligned;
    logic        al_illegal;

    store_lane_align u_align (
        .addr       (mwr_st_addr[1:0]),
        .data       (mwr_st_data),
        .funct3     (mwr_st_funct3),
        .wdata      (al_wdata),
        .be         (al_be),
        .misaligned (al_misaligned),
        .illegal    (al_illegal)
    );

    assign mwr_st_ready = (state_q == MWR_IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        case (state_q)
            MWR_IDLE: begin
                // Rejected stores leave the memory-side registers untouched.
                if (mwr_st_valid) begin
                    if (al_illegal) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_ILLEGAL;
                    end else if (al_misaligned) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_MISALIGN;
                    end else begin
                        state_d     = MWR_BUSY;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = {mwr_st_addr[31:2], 2'b00};
                        mem_wdata_d = al_wdata;
                        mem_be_d    = al_be;
                    end
                end
            end
            MWR_BUSY: begin
                // Ack is tested first so a last-cycle ack still completes.
                if (mwr_mem_ack) begin
                    state_d   = MWR_IDLE;
                    cnt_d     = '0;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                end else if (cnt_q == TIMEOUT_W'(TIMEOUT - 1)) begin
                    state_d    = MWR_IDLE;
                    cnt_d      = '0;
                    mem_req_d  = 1'b0;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            default: state_d = MWR_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge mwr_clk or negedge mwr_rst_n) begin
        if (!mwr_rst_n) begin
            state_q     <= MWR_IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign mwr_mem_req   = mem_req_q;
    assign mwr_mem_addr  = mem_addr_q;
    assign mwr_mem_wdata = mem_wdata_q;
    assign mwr_mem_be    = mem_be_q;
    assign mwr_done      = done_q;
    assign mwr_err       = err_q;
    assign mwr_err_code  = err_code_q;

endmodule

// File: tb/tb_memory_write_register.sv
// Scoreboard bench for memory_write_register: a byte-level store model fills
// an expectation queue, a negedge monitor checks every done/err response.
module tb_memory_write_register;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    memory_write_register #(.TIMEOUT(TIMEOUT), .TIMEOUT_W(5)) dut (
        .mwr_clk       (clk),
        .mwr_rst_n     (rst_n),
        .mwr_st_valid  (st_valid),
        .mwr_st_ready  (st_ready),
        .mwr_st_addr   (st_addr),
        .mwr_st_data   (st_data),
        .mwr_st_funct3 (st_funct3),
        .mwr_mem_req   (mem_req),
        .mwr_mem_addr  (mem_addr),
        .mwr_mem_wdata (mem_wdata),
        .mwr_mem_be    (mem_be),
        .mwr_mem_ack   (mem_ack),
        .mwr_done      (done),
        .mwr_err       (err),
        .mwr_err_code  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          req_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Store modelled as a byte-range write: size bytes starting at addr, each lane
    // carrying the rs2 byte selected by its position modulo the access size.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] d,
                                   input logic [2:0] f3, input int ack_lat);
        exp_t e;
        int   size;
        int   off;
        e.is_err = 1'b0; e.code = 2'b00; e.addr = '0; e.wdata = '0; e.be = '0; e.req_cycles = 0;
        if (f3 > 3'd2) begin
            e.is_err = 1'b1; e.code = 2'b10;
            return e;
        end
        size = 1 << f3;
        off  = int'(a % 4);
        if ((a % size) != 0) begin
            e.is_err = 1'b1; e.code = 2'b01;
            return e;
        end
        e.addr = a - (a % 4);
        for (int i = 0; i < 4; i++) begin
            e.wdata[8*i +: 8] = d[8*(i % size) +: 8];
            e.be[i]           = (i >= off) && (i < off + size);
        end
        if (ack_lat >= 1 && ack_lat <= TIMEOUT) begin
            e.req_cycles = ack_lat;
        end else begin
            e.is_err = 1'b1; e.code = 2'b11; e.req_cycles = TIMEOUT;
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge of the response cycle.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] f3, input int ack_lat);
        exp_t e;
        int   w;
        w = 0;
        while (!st_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", 32'(st_ready), 32'd1);
        if (!st_ready) return;
        e = model(a, d, f3, ack_lat);
        exp_q.push_back(e);
        st_valid = 1'b1; st_addr = a; st_data = d; st_funct3 = f3;
        @(negedge clk);
        st_valid = 1'b0; st_addr = $urandom; st_data = $urandom; st_funct3 = 3'($urandom);
        if (e.req_cycles > 0) begin
            for (int k = 1; k <= TIMEOUT; k++) begin
                mem_ack = (k == ack_lat);
                @(negedge clk);
                if (k == ack_lat) break;
            end
            mem_ack = 1'b0;
        end
    endtask

    // Monitor: checks invariants every cycle and scores each done/err pulse.
    initial begin
        int          req_cnt;
        bit          have_cap;
        logic [31:0] cap_addr, cap_wdata;
        logic [3:0]  cap_be;
        logic [1:0]  held_code;
        exp_t        e;
        req_cnt = 0; have_cap = 0; held_code = 2'b00;
        cap_addr = '0; cap_wdata = '0; cap_be = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                req_cnt = 0; have_cap = 0; held_code = 2'b00;
            end else begin
                check("ready_is_not_req", 32'(st_ready), 32'(!mem_req));
                check("done_and_err", 32'(done & err), 32'd0);
                if (mem_req) begin
                    if (!have_cap) begin
                        cap_addr = mem_addr; cap_wdata = mem_wdata; cap_be = mem_be;
                        have_cap = 1;
                    end else begin
                        check("hold_addr", mem_addr, cap_addr);
                        check("hold_wdata", mem_wdata, cap_wdata);
                        check("hold_be", 32'(mem_be), 32'(cap_be));
                    end
                    req_cnt++;
                end
                if (done || err) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", {30'd0, done, err}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_is_err", 32'(err), 32'(e.is_err));
                        check("req_cycles", 32'(req_cnt), 32'(e.req_cycles));
                        check("req_low_at_resp", 32'(mem_req), 32'd0);
                        if (e.is_err) begin
                            check("err_code", 32'(err_code), 32'(e.code));
                            held_code = e.code;
                        end else begin
                            check("mem_addr", cap_addr, e.addr);
                            check("mem_wdata", cap_wdata, e.wdata);
                            check("mem_be", 32'(cap_be), 32'(e.be));
                        end
                    end
                    req_cnt = 0; have_cap = 0;
                end else begin
                    check("err_code_held", 32'(err_code), 32'(held_code));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] f3;
        int         r;
        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(st_ready), 32'd1);
        check("rst_outputs", {mem_req, done, err, err_code, mem_be}, 32'd0);
        check("rst_addr_wdata", mem_addr | mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        do_store(32'h0000_1003, 32'h0000_00A5, 3'b000, 3);
        do_store(32'h0000_2002, 32'h1234_BEEF, 3'b001, 1);
        do_store(32'h0000_3000, 32'hCAFE_0001, 3'b010, 1);
        do_store(32'h0000_3004, 32'hCAFE_0002, 3'b010, 1);
        do_store(32'h0000_3001, 32'h1111_1111, 3'b010, 1);
        do_store(32'h0000_3001, 32'h2222_2222, 3'b011, 1);
        do_store(32'h0000_3000, 32'h3333_3333, 3'b010, 0);
        do_store(32'h0000_3000, 32'h4444_4444, 3'b010, TIMEOUT);
        do_store(32'h0000_5005, 32'h5555_5555, 3'b001, 1);

        // Randomized stores with ack noise while idle
        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 3)      f3 = 3'b000;
            else if (r < 6) f3 = 3'b001;
            else if (r < 9) f3 = 3'b010;
            else            f3 = 3'($urandom_range(3, 7));
            r = ($urandom_range(0, 7) == 0) ? 17 : int'($urandom_range(1, 6));
            do_store($urandom, $urandom, f3, r);
            if ($urandom_range(0, 3) == 0) begin
                mem_ack = 1'b1;
                @(negedge clk);
                mem_ack = 1'b0;
            end
        end

        // Reset between edges while BUSY: store must vanish silently
        st_valid = 1'b1; st_addr = 32'h0000_4000; st_data = 32'h7777_7777; st_funct3 = 3'b010;
        @(negedge clk);
        st_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_before_rst", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("req_async_drop", 32'(mem_req), 32'd0);
        check("no_done_err_rst", {30'd0, done, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(st_ready), 32'd1);
        check("post_rst_outputs", {mem_req, done, err, err_code, mem_be}, 32'd0);
        check("post_rst_addr_wdata", mem_addr | mem_wdata, 32'd0);
        repeat (3) @(negedge clk);

        do_store(32'h0000_6006, 32'hABCD_1234, 3'b001, 2);
        do_store(32'h0000_6007, 32'hABCD_1234, 3'b001, 2);
        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
